// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: shared state and line types for the icache/dcache memory arbiter
package cache_arbiter_pkg;
  localparam int LINE_BITS = 128;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef logic [LINE_BITS-1:0] lc3b_line;
endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: cache-side and pmem-side line ports of the arbiter
interface cache_arbiter_if #(parameter int ADDR_W = 16, parameter int LINE_W = 128);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport slave (
    input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
           pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp, pmem_read, pmem_write,
           pmem_address, pmem_wdata
  );
  modport master (
    output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
           pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp, pmem_read, pmem_write,
           pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter_arb_select.sv
// arb_select: single-request priority with round-robin tie-break (last_grant 1 = dcache)
module arb_select (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_d
);
  assign grant_d = d_req & (~i_req | ~last_grant);
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants the shared pmem line port to icache or dcache, one transaction at a time
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);
  arb_state_t        state, state_n;
  logic              last_grant, grant_d, write_q, i_req, d_req, resp_i, resp_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  arb_select sel (.i_req(i_req), .d_req(d_req), .last_grant(last_grant), .grant_d(grant_d));
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (i_req | d_req) ? (grant_d ? SERVE_D : SERVE_I) : IDLE;
    else if (state == DONE) state_n = IDLE;
    else if (bus.pmem_resp) state_n = DONE;
  end
  assign resp_i           = (state == SERVE_I) & bus.pmem_resp;
  assign resp_d           = (state == SERVE_D) & bus.pmem_resp;
  assign bus.pmem_read    = (state == SERVE_I) | ((state == SERVE_D) & ~write_q);
  assign bus.pmem_write   = (state == SERVE_D) & write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_resp  = resp_i;
  assign bus.d_pmem_resp  = resp_d;
  assign bus.i_pmem_rdata = resp_i ? bus.pmem_rdata : i_rdata_q;
  assign bus.d_pmem_rdata = resp_d ? bus.pmem_rdata : d_rdata_q;
  // A simultaneous dcache read+write is taken as a write-back
  always_ff @(posedge clk)
    if (reset) begin
      last_grant <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE && (i_req || d_req)) begin
        addr_q  <= grant_d ? bus.d_pmem_address : bus.i_pmem_address;
        write_q <= grant_d & bus.d_pmem_write;
        if (grant_d) wdata_q <= bus.d_pmem_wdata;
      end
      if (resp_i) begin
        i_rdata_q  <= bus.pmem_rdata;
        last_grant <= 1'b0;
      end
      if (resp_d) begin
        d_rdata_q  <= bus.pmem_rdata;
        last_grant <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: per-cycle vector table plus directed multi-transaction sequences
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;
  typedef struct {
    logic ir; logic [15:0] ia; logic dr; logic dw; logic [15:0] da; logic pr; lc3b_line prd;
    logic er; logic ew; logic [15:0] ea; logic eir; logic edr; lc3b_line eird; lc3b_line edrd;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, fails = 0;
  vec_t v[15];
  lc3b_line la, lb, lc, ld, lz, wd;
  cache_arbiter_if bus();
  cache_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic clear_inputs;
    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
  endtask
  task automatic rst_dut;
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
  endtask
  task automatic serve(input logic side_d, input logic wr, input logic [15:0] a, input lc3b_line w,
                       input lc3b_line rd);
    int n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("grant_timeout", {127'b0, n < 10}, 1);
    check("serve_read", bus.pmem_read, !wr);
    check("serve_write", bus.pmem_write, wr);
    check("serve_addr", bus.pmem_address, a);
    if (wr) check("serve_wdata", bus.pmem_wdata, w);
    @(negedge clk);
    bus.pmem_resp = 1; bus.pmem_rdata = rd;
    #1;
    check("resp_i", bus.i_pmem_resp, !side_d);
    check("resp_d", bus.d_pmem_resp, side_d);
    check("resp_rdata", side_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, rd);
    @(negedge clk);
    bus.pmem_resp = 0;
    if (side_d) begin bus.d_pmem_read = 0; bus.d_pmem_write = 0; end
    else bus.i_pmem_read = 0;
    #1;
    check("done_quiet", {bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp}, 0);
  endtask
  initial begin
    la = {8{16'hAAAA}}; lb = {8{16'hBBBB}}; lc = {8{16'hCCCC}}; ld = {8{16'hDDDD}}; lz = '0;
    wd = {2{64'h0123456789ABCDEF}};
    v[0]  = '{1, 16'h1230, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h0000, 0, 0, lz, lz};
    v[1]  = '{1, 16'h1230, 0, 0, 16'h0000, 0, lz, 1, 0, 16'h1230, 0, 0, lz, lz};
    v[2]  = '{1, 16'h1230, 0, 0, 16'h0000, 0, lz, 1, 0, 16'h1230, 0, 0, lz, lz};
    v[3]  = '{1, 16'h1230, 0, 0, 16'h0000, 1, la, 1, 0, 16'h1230, 1, 0, la, lz};
    v[4]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h1230, 0, 0, la, lz};
    v[5]  = '{0, 16'h0000, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h1230, 0, 0, la, lz};
    v[6]  = '{1, 16'h0040, 1, 0, 16'h2000, 0, lz, 0, 0, 16'h1230, 0, 0, la, lz};
    v[7]  = '{1, 16'h0040, 1, 0, 16'h2000, 0, lz, 1, 0, 16'h2000, 0, 0, la, lz};
    v[8]  = '{1, 16'h0040, 1, 0, 16'h2000, 1, lb, 1, 0, 16'h2000, 0, 1, la, lb};
    v[9]  = '{1, 16'h0040, 0, 0, 16'h2000, 0, lz, 0, 0, 16'h2000, 0, 0, la, lb};
    v[10] = '{1, 16'h0040, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h2000, 0, 0, la, lb};
    v[11] = '{1, 16'h0040, 0, 0, 16'h0000, 1, lc, 1, 0, 16'h0040, 1, 0, lc, lb};
    v[12] = '{0, 16'h0000, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h0040, 0, 0, lc, lb};
    v[13] = '{0, 16'h0000, 0, 0, 16'h0000, 1, ld, 0, 0, 16'h0040, 0, 0, lc, lb};
    v[14] = '{0, 16'h0000, 0, 0, 16'h0000, 0, lz, 0, 0, 16'h0040, 0, 0, lc, lb};
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("rst_read", bus.pmem_read, 0);
    check("rst_write", bus.pmem_write, 0);
    check("rst_addr", bus.pmem_address, 0);
    check("rst_wdata", bus.pmem_wdata, 0);
    check("rst_resps", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    check("rst_i_rdata", bus.i_pmem_rdata, 0);
    check("rst_d_rdata", bus.d_pmem_rdata, 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.i_pmem_read = v[k].ir; bus.i_pmem_address = v[k].ia;
      bus.d_pmem_read = v[k].dr; bus.d_pmem_write = v[k].dw; bus.d_pmem_address = v[k].da;
      bus.pmem_resp = v[k].pr; bus.pmem_rdata = v[k].prd;
      #1;
      check($sformatf("r%0d_read", k), bus.pmem_read, v[k].er);
      check($sformatf("r%0d_write", k), bus.pmem_write, v[k].ew);
      check($sformatf("r%0d_addr", k), bus.pmem_address, v[k].ea);
      check($sformatf("r%0d_i_resp", k), bus.i_pmem_resp, v[k].eir);
      check($sformatf("r%0d_d_resp", k), bus.d_pmem_resp, v[k].edr);
      check($sformatf("r%0d_i_rdata", k), bus.i_pmem_rdata, v[k].eird);
      check($sformatf("r%0d_d_rdata", k), bus.d_pmem_rdata, v[k].edrd);
    end
    rst_dut();
    bus.i_pmem_read = 1; bus.i_pmem_address = 16'h0080;
    bus.d_pmem_write = 1; bus.d_pmem_address = 16'h3000; bus.d_pmem_wdata = wd;
    @(negedge clk);
    bus.d_pmem_wdata = '0;
    #1;
    serve(1, 1, 16'h3000, wd, lz);
    bus.d_pmem_read = 1; bus.d_pmem_address = 16'h4000;
    serve(0, 0, 16'h0080, lz, lc);
    serve(1, 0, 16'h4000, lz, lb);
    rst_dut();
    bus.i_pmem_address = 16'h0100; bus.d_pmem_address = 16'h5000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      bus.i_pmem_read = 1; bus.d_pmem_read = 1;
      #1;
      serve(k % 2 == 0, 0, (k % 2 == 0) ? 16'h5000 : 16'h0100, lz, (k % 2 == 0) ? la : lb);
    end
    rst_dut();
    bus.d_pmem_read = 1; bus.d_pmem_address = 16'h6000;
    @(negedge clk); #1;
    check("pre_reset_read", bus.pmem_read, 1);
    reset = 1;
    @(negedge clk); #1;
    check("reset_strobes", {bus.pmem_read, bus.pmem_write}, 0);
    reset = 0; bus.d_pmem_read = 0;
    @(negedge clk);
    bus.pmem_resp = 1; bus.pmem_rdata = ld;
    #1;
    check("stray_resp", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    check("stray_strobes", {bus.pmem_read, bus.pmem_write}, 0);
    @(negedge clk);
    bus.pmem_resp = 0; bus.i_pmem_read = 1; bus.i_pmem_address = 16'h7000;
    #1;
    serve(0, 0, 16'h7000, lz, ld);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
